// File: rtl/i2s_rx_ctrl.sv
// I2S master receiver: sclk/ws generation, sample capture, 1-deep frame buffer.
// Optional I2S_FRAME_CNT_EN adds frameCnt_o, a count of frames loaded.
`timescale 1ns/1ps
module i2s_rx_ctrl #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic               clk_i,
  input  logic               rstN_i,
  input  logic               en_i,
  input  logic               sdata_i,
  output logic               sclk_o,
  output logic               ws_o,
  output logic [2*WIDTH-1:0] frameData_o,
  output logic               frameValid_o,
  input  logic               frameReady_i,
  output logic               overflow_o,
  input  logic               overflowClr_i,
`ifdef I2S_FRAME_CNT_EN
  output logic [15:0]        frameCnt_o,
`endif
  output logic               busy_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] BIT_LSB  = BW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]    div_q;
  logic [BW-1:0]    bit_q;
  logic             slot_q;
  logic             armed_q;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH-2:0] right_q;
  logic [WIDTH-1:0] right_nx;

  logic tc, rise, fall, wrap;
  logic stop_ev, capture;
  logic complete, accept;

  assign tc      = (state_q != IDLE) && (div_q == DIV_LAST);
  assign rise    = tc && !sclk_o;
  assign fall    = tc && sclk_o;
  assign wrap    = fall && (bit_q == BIT_LAST);
  assign stop_ev = (state_q == STOP) && wrap && slot_q;

  // bitCnt 0 is the I2S one-bit delay; beyond WIDTH is padding
  assign capture = rise && (bit_q != '0) && (bit_q <= BIT_LSB);

  assign right_nx = {right_q, sdata_i};
  assign complete = capture && slot_q && armed_q &&
                    (bit_q == BIT_LSB);
  assign accept   = complete &&
                    (!frameValid_o || frameReady_i);

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en_i)    state_d = RUN;
      RUN:     if (!en_i)   state_d = STOP;
      STOP:    if (stop_ev) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      div_q   <= '0;
      bit_q   <= '0;
      slot_q  <= 1'b0;
      armed_q <= 1'b0;
      sclk_o  <= 1'b0;
      ws_o    <= 1'b1;
      left_q  <= '0;
      right_q <= '0;
    end else if (state_q == IDLE) begin
      sclk_o <= 1'b0;
      ws_o   <= 1'b1;
      if (en_i) begin
        div_q   <= '0;
        bit_q   <= BIT_LAST;
        slot_q  <= 1'b1;
        armed_q <= 1'b0;
      end
    end else begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) sclk_o <= ~sclk_o;
      // the stopping fall leaves ws high and parks the counters
      if (fall && !stop_ev) begin
        bit_q <= wrap ? '0 : bit_q + 1'b1;
        if (wrap) begin
          ws_o   <= ~ws_o;
          slot_q <= ~slot_q;
        end
      end
      if (capture) begin
        if (slot_q) right_q <= right_nx[WIDTH-2:0];
        else        left_q  <= {left_q[WIDTH-2:0], sdata_i};
      end
      if (capture && !slot_q && (bit_q == BIT_LSB))
        armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      frameData_o  <= '0;
      frameValid_o <= 1'b0;
    end else if (accept) begin
      frameData_o  <= {left_q, right_nx};
      frameValid_o <= 1'b1;
    end else if (frameValid_o && frameReady_i) begin
      frameValid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i)                 overflow_o <= 1'b0;
    else if (complete && !accept) overflow_o <= 1'b1;
    else if (overflowClr_i)      overflow_o <= 1'b0;
  end

`ifdef I2S_FRAME_CNT_EN
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i)     frameCnt_o <= '0;
    else if (accept) frameCnt_o <= frameCnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl: ADC bit driver, frame scoreboard,
// timing, overflow, simultaneous handshake, clean stop and async reset.
`timescale 1ns/1ps
module tb_i2s_rx_ctrl;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rstN, en, sdata, ready, clr;
  logic        sclk, ws, valid, ovf, busy;
  logic [31:0] data;
`ifdef I2S_FRAME_CNT_EN
  logic [15:0] fcnt;
`endif

  always #5 clk = ~clk;

  i2s_rx_ctrl dut (
    .clk_i         (clk),
    .rstN_i        (rstN),
    .en_i          (en),
    .sdata_i       (sdata),
    .sclk_o        (sclk),
    .ws_o          (ws),
    .frameData_o   (data),
    .frameValid_o  (valid),
    .frameReady_i  (ready),
    .overflow_o    (ovf),
    .overflowClr_i (clr),
`ifdef I2S_FRAME_CNT_EN
    .frameCnt_o    (fcnt),
`endif
    .busy_o        (busy)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];
  logic [15:0] lw, rw;
  int          idx;
  logic        prev_ws;
  time         last_hs, prev_hs, t0, t1, tf, t_en;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sclk;
      1:       return ws;
      2:       return valid;
      3:       return busy;
      default: return ovf;
    endcase
  endfunction

  task automatic wait_edge(input int sel, input logic lvl,
                           input int lim, input string tag);
    logic p;
    bit   ok;
    p  = sig(sel);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (p !== lvl && sig(sel) === lvl) begin
        ok = 1;
        break;
      end
      p = sig(sel);
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_drain(input int lim, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1);
  endtask

  // ADC model: new bit after each sclk fall, MSB one sclk after ws edge
  always @(negedge sclk) begin
    #1;
    if (ws !== prev_ws) idx = 0;
    else                idx++;
    prev_ws = ws;
    if (idx >= 1 && idx <= W) sdata = ws ? rw[W-idx] : lw[W-idx];
    else                      sdata = 1'b0;
  end

  always @(negedge clk) begin
    if (rstN && valid && ready) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) chk("frame", data, sb_q.pop_front());
      prev_hs = last_hs;
      last_hs = $time;
    end
  end

  initial begin
    rstN = 0; en = 0; sdata = 0; ready = 0; clr = 0;
    lw = '0; rw = '0; idx = 0; prev_ws = 1'b1;
    last_hs = 0; prev_hs = 0;
    repeat (3) tick();
    chk("rst_sclk", sclk, 0);
    chk("rst_ws", ws, 1);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
`ifdef I2S_FRAME_CNT_EN
    chk("rst_cnt", fcnt, 0);
`endif
    rstN = 1;
    tick();
    chk("idle_sclk", sclk, 0);
    chk("idle_busy", busy, 0);

    // streaming with ready held high
    lw = 16'hA5C3; rw = 16'h1234; ready = 1;
    sb_q.push_back(32'hA5C31234);
    sb_q.push_back(32'hA5C31234);
    en = 1;
    wait_edge(0, 1, 20, "a_rise1");
    t0 = $time;
    chk("a_busy", busy, 1);
    chk("a_ws_pre", ws, 1);
    wait_edge(0, 0, 20, "a_fall1");
    tf = $time;
    chk("a_ws_first_fall", ws, 0);
    wait_edge(0, 1, 20, "a_rise2");
    t1 = $time;
    chk("sclk_period", t1 - t0, 80);
    wait_edge(1, 1, 600, "a_ws_rise");
    chk("ws_period", $time - tf, 2560);
    wait_drain(1500, "a_drain");
    chk("valid_pulse", valid, 0);
    chk("hs_interval", last_hs - prev_hs, 5120);
    chk("a_ovf", ovf, 0);

    // back-pressure across two completions
    ready = 0;
    lw = 16'h1111; rw = 16'h2222;
    sb_q.push_back(32'h11112222);
    wait_edge(2, 1, 1200, "b_valid");
    lw = 16'h3333; rw = 16'h4444;
    wait_edge(4, 1, 1200, "b_ovf_rise");
    chk("b_hold_data", data, 32'h11112222);
    chk("b_hold_valid", valid, 1);
    chk("b_ovf", ovf, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("b_ovf_clr", ovf, 0);
    sb_q.push_back(32'h33334444);
    ready = 1;
    tick();
    ready = 0;
    chk("b_valid_drop", valid, 0);

    // ready arrives in the very cycle of the next completion
    wait_edge(2, 1, 1200, "c_valid");
    lw = 16'h5555; rw = 16'h6666;
    sb_q.push_back(32'h55556666);
    wait_edge(1, 1, 700, "c_ws_rise");
    for (int i = 0; i < 16; i++) wait_edge(0, 1, 20, "c_rise");
    repeat (7) tick();
    ready = 1;
    tick();
    ready = 0;
    chk("c_ovf", ovf, 0);
    chk("c_valid", valid, 1);
    chk("c_data", data, 32'h55556666);
    ready = 1;
    tick();
    chk("c_sb_empty", sb_q.size(), 0);

    // drop enable mid left slot
    lw = 16'h7777; rw = 16'h8888;
    sb_q.push_back(32'h77778888);
    wait_edge(1, 0, 700, "d_ws_fall");
    for (int i = 0; i < 10; i++) wait_edge(0, 1, 20, "d_rise");
    en = 0;
    wait_edge(3, 0, 1500, "d_idle");
    chk("d_sclk", sclk, 0);
    chk("d_ws", ws, 1);
    chk("d_sb_empty", sb_q.size(), 0);
    repeat (4) tick();
    chk("d_hold_sclk", sclk, 0);
    chk("d_hold_busy", busy, 0);

    lw = 16'h9999; rw = 16'hAAAA;
    sb_q.push_back(32'h9999AAAA);
    en = 1;
    t_en = $time;
    wait_drain(1500, "d_restart_drain");
    chk("restart_latency", last_hs - t_en, 3974);

    // asynchronous reset mid right slot
    wait_edge(1, 1, 700, "e_ws_rise");
    for (int i = 0; i < 5; i++) wait_edge(0, 1, 20, "e_rise");
    rstN = 0;
    en = 0;
    #1;
    chk("e_sclk", sclk, 0);
    chk("e_ws", ws, 1);
    chk("e_data", data, 0);
    chk("e_valid", valid, 0);
    chk("e_ovf", ovf, 0);
    chk("e_busy", busy, 0);
`ifdef I2S_FRAME_CNT_EN
    chk("e_cnt", fcnt, 0);
`endif
    idx = 0;
    prev_ws = 1'b1;
    repeat (2) tick();
    rstN = 1;
    lw = 16'hBEEF; rw = 16'hCAFE;
    repeat (3) sb_q.push_back(32'hBEEFCAFE);
    en = 1;
    wait_drain(2500, "e_drain");
`ifdef I2S_FRAME_CNT_EN
    chk("e_cnt3", fcnt, 3);
`endif
    en = 0;
    wait_edge(3, 0, 800, "e_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
I2S master-mode receive controller for the audio input path. Generates the serial bit clock and word-select from the system clock, samples the serial data line at the correct bit positions, and assembles stereo frames. Hands each frame to the downstream FIFO/DSP through a one-entry valid/ready buffer, flags overflow when a frame is lost, and starts and stops only on clean frame boundaries.

Parameters:
WIDTH, 16, audio sample bits per channel.
SLOT_BITS, 32, sclk periods per channel slot; must be >= WIDTH+1.
CLK_DIV, 4, clk_i cycles per sclk half-period; must be >= 2. sclk period = 2*CLK_DIV clk_i cycles.

Ports:
clk_i  in  1  system clock; all logic on its rising edge.
rstN_i  in  1  asynchronous, active-low reset.
en_i  in  1  run request; level sensitive.
sdata_i  in  1  serial audio data from the ADC/mic, already synchronised.
sclk_o  out  1  I2S bit clock, registered.
ws_o  out  1  I2S word select, registered; 0 = left, 1 = right.
frameData_o  out  2*WIDTH  {left, right}; left occupies the upper WIDTH bits.
frameValid_o  out  1  frameData_o holds an unconsumed frame.
frameReady_i  in  1  downstream accepts the frame when frameValid_o && frameReady_i.
overflow_o  out  1  sticky lost-frame flag.
overflowClr_i  in  1  clears overflow_o.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: sclk_o=0, ws_o=1, frameData_o=0, frameValid_o=0, overflow_o=0, busy_o=0. State is IDLE, all counters are 0 and both shift registers are 0.
- Divider: divCnt counts 0..CLK_DIV-1 in RUN/STOP. At the terminal count sclk_o toggles.
  - A 0->1 toggle is a rise event; a 1->0 toggle is a fall event. Each event is a one-cycle internal strobe.
- States and transitions:
  - IDLE: no clocks run; sclk_o=0, ws_o=1. On en_i=1: divCnt=0, bitCnt=SLOT_BITS-1, slot=right, then go to RUN.
  - RUN: on each fall event, bitCnt increments. When it wraps from SLOT_BITS-1 to 0, ws_o and slot toggle on that same fall. If en_i=0, go to STOP.
  - STOP: runs exactly like RUN until the fall event on which the right slot would wrap to left. On that event sclk_o goes to 0, ws_o stays 1, and the state returns to IDLE. en_i re-asserting during STOP does not cancel the stop; after reaching IDLE, the controller restarts one cycle later.
- Sampling:
  - On a rise event with bitCnt in 1..WIDTH, sdata_i shifts MSB-first into the current slot's shift register.
  - Rise events at bitCnt 0 or bitCnt > WIDTH are ignored (the one-bit I2S delay plus padding).
- Frame completion: the rise event in the right slot with bitCnt==WIDTH, after the final right bit has been shifted in. The first partial frame after start (right slot) is discarded: completion is only armed once a left slot has been fully captured since start.
- Output buffer:
  - On completion with the buffer empty, or with frameReady_i=1 in the same cycle: load {left,right} and set frameValid_o=1. The simultaneous case loses no frame and does not overflow.
  - On completion with frameValid_o=1 and frameReady_i=0: the new frame is dropped, the old frame stays stable, and overflow_o is set.
  - On a handshake with no completion: frameValid_o goes to 0 the next cycle.
  - frameData_o is held stable while frameValid_o=1.
- overflowClr_i clears overflow_o. If a clear and a set happen in the same cycle, the set wins.
- Latency: frameValid_o rises 1 clk after the completion rise event.
- Asynchronous reset mid-frame returns every output to its reset value immediately. The partial frame is lost.

Optional Feature:
I2S_FRAME_CNT_EN: adds output frameCnt_o [15:0], reset 0. It increments on every frame loaded into the buffer (dropped frames are not counted) and wraps from 0xFFFF to 0. When the macro is not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then en_i=1 with WIDTH=16, SLOT_BITS=32, CLK_DIV=4 -> sclk_o period 8 clk; ws_o falls on the first sclk fall; ws_o toggles every 32 sclk periods.
- Drive left=0xA5C3 and right=0x1234 MSB-first, starting one sclk after each ws edge, with frameReady_i=1 -> frameData_o=0xA5C31234 with frameValid_o pulsing 1 cycle, once per 512 clk.
- Hold frameReady_i=0 across two completions -> first frame held stable, second dropped, overflow_o=1. Pulse overflowClr_i -> overflow_o=0.
- Assert frameReady_i in the exact cycle a new frame completes -> old frame accepted, new frame loaded, overflow_o stays 0.
- Drop en_i mid left slot -> the controller finishes the right slot, delivers that frame, then goes idle with sclk_o=0, ws_o=1, busy_o=0. Re-assert en_i -> the first partial right slot is discarded.
- Assert rstN_i low mid-right-slot -> all outputs at reset values immediately. With I2S_FRAME_CNT_EN defined, frameCnt_o=0 after reset and equals 3 after three accepted frames.
